// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types and rotating-priority pick helper for rr_mux_arbiter
package rr_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef logic [SEL_W-1:0]   sel_t;
  typedef logic [NUM_REQ-1:0] req_vec_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_t;

  typedef struct packed {
    logic found;
    sel_t idx;
  } pick_t;

  // Walk from the farthest candidate back to ptr so the closest requester wins.
  function automatic pick_t rr_pick(req_vec_t req, sel_t ptr);
    pick_t res;
    sel_t  cand;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + sel_t'(k);
      if (req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick_logic.sv
// rtl/rr_pick_logic.sv - combinational priority rotate: first requester at or after ptr
module rr_pick_logic
  import rr_arb_pkg::*;
(
  input  req_vec_t req,
  input  sel_t     ptr,
  output logic     found,
  output sel_t     idx
);

  pick_t pick;

  assign pick  = rr_pick(req, ptr);
  assign found = pick.found;
  assign idx   = pick.idx;

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - 4-way round-robin arbiter feeding one registered valid/ready slot
// Optional grant lock input when ARB_LOCK_EN is defined.
module rr_mux_arbiter
  import rr_arb_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int NUM_REQ = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
`ifdef ARB_LOCK_EN
  input  logic [3:0]        lock,
`endif
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  input  logic [DATA_W-1:0] data_c,
  input  logic [DATA_W-1:0] data_d,
  output logic [3:0]        gnt,
  output logic [1:0]        sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_src,
  input  logic              out_ready
);

  if (NUM_REQ != 4) begin : g_bad_num_req
    $error("rr_mux_arbiter supports NUM_REQ == 4 only");
  end

  slot_t             slot_q, slot_d;
  sel_t              ptr_q, last_q;
  logic              pick_found;
  sel_t              pick_idx;
  logic              win_found;
  sel_t              win_idx;
  logic              lock_hold;
  logic              can_accept;
  logic              accept;
  logic [DATA_W-1:0] mux_data;

  rr_pick_logic u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef ARB_LOCK_EN
  logic granted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) granted_q <= 1'b0;
    else if (accept) granted_q <= 1'b1;
  end
`endif

  // A held lock overrides rotation and keeps ptr where it is.
  always_comb begin
    win_found = pick_found;
    win_idx   = pick_idx;
    lock_hold = 1'b0;
`ifdef ARB_LOCK_EN
    if (granted_q && lock[last_q] && req[last_q]) begin
      win_found = 1'b1;
      win_idx   = last_q;
      lock_hold = 1'b1;
    end
`endif
  end

  assign out_valid  = (slot_q == SLOT_FULL);
  assign can_accept = !out_valid || out_ready;
  assign accept     = can_accept && win_found;
  assign gnt        = accept ? (req_vec_t'(1) << win_idx) : '0;
  assign sel        = accept ? win_idx : last_q;

  always_comb begin
    mux_data = data_a;
    case (sel)
      2'd0: mux_data = data_a;
      2'd1: mux_data = data_b;
      2'd2: mux_data = data_c;
      2'd3: mux_data = data_d;
      default: mux_data = data_a;
    endcase
  end

  always_comb begin
    slot_d = slot_q;
    case (slot_q)
      SLOT_EMPTY: if (accept) slot_d = SLOT_FULL;
      SLOT_FULL:  if (out_ready) slot_d = accept ? SLOT_FULL : SLOT_EMPTY;
      default:    slot_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q   <= SLOT_EMPTY;
      ptr_q    <= '0;
      last_q   <= '0;
      out_data <= '0;
      out_src  <= '0;
    end else begin
      slot_q <= slot_d;
      if (accept) begin
        out_data <= mux_data;
        out_src  <= win_idx;
        last_q   <= win_idx;
        if (!lock_hold) ptr_q <= win_idx + sel_t'(1);
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - scoreboard bench for rr_mux_arbiter (lock tests when ARB_LOCK_EN defined)
module tb_rr_mux_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] lock;
  logic [3:0] data_a, data_b, data_c, data_d;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       out_valid;
  logic [3:0] out_data;
  logic [1:0] out_src;
  logic       out_ready;

  int total = 0;
  int bad   = 0;

  logic [5:0] exp_q[$];
  logic [3:0] data_tbl [4];

  rr_mux_arbiter #(.DATA_W(4), .NUM_REQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
`ifdef ARB_LOCK_EN
    .lock      (lock),
`endif
    .data_a    (data_a),
    .data_b    (data_b),
    .data_c    (data_c),
    .data_d    (data_d),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Drive one cycle; check the grant at mid-cycle and queue the word it should produce.
  task automatic step(input logic [3:0] r, input logic rdy, input logic [3:0] eg);
    int i;
    @(posedge clk);
    #1;
    req       = r;
    out_ready = rdy;
    @(negedge clk);
    chk("gnt", int'(gnt), int'(eg));
    if (eg != 4'b0000) begin
      i = onehot_idx(eg);
      chk("sel", int'(sel), i);
      exp_q.push_back({2'(i), data_tbl[i]});
    end
  endtask

  // Monitor: a word leaves the slot at the next edge whenever valid & ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", int'({out_src, out_data}), -1);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        chk("out_word", int'({out_src, out_data}), int'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    data_a = 4'b0000; data_b = 4'b1001; data_c = 4'b0011; data_d = 4'b1000;
    data_tbl[0] = 4'b0000; data_tbl[1] = 4'b1001;
    data_tbl[2] = 4'b0011; data_tbl[3] = 4'b1000;
    req = 4'b0000; lock = 4'b0000; out_ready = 1'b1; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_src", int'(out_src), 0);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_sel", int'(sel), 0);
    rst_n = 1'b1;

    // full request set rotates with no bubbles
    step(4'b1111, 1'b1, 4'b0001);
    step(4'b1111, 1'b1, 4'b0010);
    chk("t1_valid", int'(out_valid), 1);
    step(4'b1111, 1'b1, 4'b0100);
    chk("t1_valid", int'(out_valid), 1);
    step(4'b1111, 1'b1, 4'b1000);
    step(4'b1111, 1'b1, 4'b0001);
    chk("t1_valid", int'(out_valid), 1);

    // partial requests: b, c, b
    step(4'b0110, 1'b1, 4'b0010);
    step(4'b0110, 1'b1, 4'b0100);
    step(4'b0110, 1'b1, 4'b0010);

    // backpressure: slot frozen on src 1, sel holds last grant
    for (int k = 0; k < 3; k++) begin
      step(4'b1111, 1'b0, 4'b0000);
      chk("t3_out_data", int'(out_data), 4'b1001);
      chk("t3_out_src", int'(out_src), 1);
      chk("t3_sel_hold", int'(sel), 1);
      chk("t3_valid", int'(out_valid), 1);
    end
    step(4'b1111, 1'b1, 4'b0100);

    // idle gap, then wrap from ptr=3 to requester 0
    for (int k = 0; k < 5; k++) step(4'b0000, 1'b1, 4'b0000);
    chk("t4_drained", int'(out_valid), 0);
    step(4'b0101, 1'b1, 4'b0001);
    step(4'b0101, 1'b1, 4'b0100);

    // async reset while the slot is full
    step(4'b0000, 1'b0, 4'b0000);
    chk("t5_full", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", int'(out_valid), 0);
    chk("t5_rst_data", int'(out_data), 0);
    chk("t5_rst_src", int'(out_src), 0);
    chk("t5_rst_gnt", int'(gnt), 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111, 1'b1, 4'b0001);
    step(4'b1000, 1'b1, 4'b1000);

`ifdef ARB_LOCK_EN
    lock = 4'b0000;
    step(4'b0010, 1'b1, 4'b0010);
    lock = 4'b0010;
    for (int k = 0; k < 4; k++) step(4'b1111, 1'b1, 4'b0010);
    lock = 4'b0000;
    step(4'b1111, 1'b1, 4'b0100);
`endif

    step(4'b0000, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);
    chk("end_valid", int'(out_valid), 0);
    chk("end_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
